bomb_game_ctrl: RTL and testbench



---
 rtl/bomb_game_ctrl_if.sv | 28 ++
 rtl/bomb_game_ctrl.sv | 114 +++++++++++
 tb/tb_bomb_game_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bomb_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bomb_game_ctrl_if
// Purpose  : Player/LED-stage inputs and game status outputs of the bomb game
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
interface bomb_game_ctrl_if;
   logic       i_Remove_Glitch_fStart;
   logic       i_Sec1Tick;
   logic [7:0] i_Key;
   logic [7:0] i_Led;
   logic [2:0] o_State;
   logic [3:0] o_Score;
   logic [5:0] o_Time_Left;
   logic       o_Hit;

   modport master (
      output i_Remove_Glitch_fStart, i_Sec1Tick, i_Key, i_Led,
      input  o_State, o_Score, o_Time_Left, o_Hit
   );

   modport slave (
      input  i_Remove_Glitch_fStart, i_Sec1Tick, i_Key, i_Led,
      output o_State, o_Score, o_Time_Left, o_Hit
   );
endinterface
`default_nettype wire

// File: rtl/bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomb_game_ctrl
// Purpose  : Bomb game master controller - scoring, countdown, clear/fail
//            decision and result hold ahead of the LED target stage.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_game_ctrl #(
   parameter int GAME_SEC    = 30,
   parameter int TARGET_HITS = 10,
   parameter int RESULT_SEC  = 3
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   bomb_game_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_START = 3'b001,
      ST_CLEAR = 3'b010,
      ST_FAIL  = 3'b011
   } state_t;

   localparam logic [5:0] C_GAME_SEC    = 6'(GAME_SEC);
   localparam logic [3:0] C_TARGET_HITS = 4'(TARGET_HITS);
   localparam logic [3:0] C_RESULT_SEC  = 4'(RESULT_SEC);

   state_t     r_state;
   logic [3:0] r_score;
   logic [5:0] r_time_left;
   logic       r_hit;
   logic       r_lockout;
   logic [3:0] r_res_cnt;

   logic       w_hit;
   logic       w_miss;
   logic       w_take_hit;
   logic [3:0] w_score_inc;
   logic [3:0] w_res_inc;

   // A pressed key matching the lit LED implies i_Led != 0.
   assign w_hit       = |(bus.i_Key & bus.i_Led);
   assign w_miss      = (|bus.i_Key) && (|bus.i_Led) && !w_hit;
   assign w_take_hit  = w_hit && !r_lockout;
   assign w_score_inc = r_score + 4'd1;
   assign w_res_inc   = r_res_cnt + 4'd1;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_state     <= ST_IDLE;
         r_score     <= 4'd0;
         r_time_left <= 6'd0;
         r_hit       <= 1'b0;
         r_lockout   <= 1'b0;
         r_res_cnt   <= 4'd0;
      end else begin
         r_hit <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_Remove_Glitch_fStart) begin
                  r_state     <= ST_START;
                  r_score     <= 4'd0;
                  r_time_left <= C_GAME_SEC;
                  r_lockout   <= 1'b0;
               end
            end

            ST_START: begin
               if (w_take_hit) begin
                  r_score   <= w_score_inc;
                  r_hit     <= 1'b1;
                  r_lockout <= 1'b1;
               end
               // The tick moves the target, so it re-arms key detection.
               if (bus.i_Sec1Tick) begin
                  r_lockout   <= 1'b0;
                  r_time_left <= (r_time_left > 6'd1) ? r_time_left - 6'd1 : 6'd0;
               end
               if (w_take_hit && (w_score_inc == C_TARGET_HITS)) begin
                  r_state   <= ST_CLEAR;
                  r_res_cnt <= 4'd0;
               end else if ((w_miss && !r_lockout) ||
                            (bus.i_Sec1Tick && (r_time_left <= 6'd1))) begin
                  r_state   <= ST_FAIL;
                  r_res_cnt <= 4'd0;
               end
            end

            ST_CLEAR, ST_FAIL: begin
               if (bus.i_Remove_Glitch_fStart) begin
                  r_state <= ST_IDLE;
               end else if (bus.i_Sec1Tick) begin
                  r_res_cnt <= w_res_inc;
                  if (w_res_inc == C_RESULT_SEC) begin
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_State     = r_state;
   assign bus.o_Score     = r_score;
   assign bus.o_Time_Left = r_time_left;
   assign bus.o_Hit       = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_game_ctrl
// Purpose  : Directed and random checks of bomb_game_ctrl against a
//            behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bomb_game_ctrl;

   localparam int GAME_SEC    = 30;
   localparam int TARGET_HITS = 10;
   localparam int RESULT_SEC  = 3;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   // Behavioural model: plain game rules, state held as the output code.
   int   m_state;
   int   m_score;
   int   m_time;
   int   m_hit;
   bit   m_armed;
   int   m_res;

   bomb_game_ctrl_if bus ();

   bomb_game_ctrl #(
      .GAME_SEC    (GAME_SEC),
      .TARGET_HITS (TARGET_HITS),
      .RESULT_SEC  (RESULT_SEC)
   ) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_score = 0; m_time = 0; m_hit = 0; m_armed = 1'b1; m_res = 0;
   endtask

   task automatic model_step(input bit st, input bit tick, input logic [7:0] key,
                             input logic [7:0] led);
      int  next;
      bit  valid;
      bit  miss;
      m_hit = 0;
      if (m_state == 0) begin
         if (st) begin
            m_state = 1; m_score = 0; m_time = GAME_SEC; m_armed = 1'b1;
         end
      end else if (m_state == 1) begin
         valid = ((key & led) != 8'd0);
         miss  = (key != 8'd0) && (led != 8'd0) && !valid;
         next  = 1;
         if (m_armed && valid) begin
            m_score += 1;
            m_hit    = 1;
            m_armed  = 1'b0;
            if (m_score == TARGET_HITS) next = 2;
         end else if (m_armed && miss) begin
            next = 3;
         end
         if (tick) begin
            m_armed = 1'b1;
            m_time  = (m_time > 0) ? m_time - 1 : 0;
            if (m_time == 0 && next == 1) next = 3;
         end
         if (next != 1) m_res = 0;
         m_state = next;
      end else begin
         if (st) m_state = 0;
         else if (tick) begin
            m_res += 1;
            if (m_res == RESULT_SEC) m_state = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("state", int'(bus.o_State), m_state);
      chk("score", int'(bus.o_Score), m_score);
      chk("time_left", int'(bus.o_Time_Left), m_time);
      chk("hit", int'(bus.o_Hit), m_hit);
   endtask

   task automatic step(input bit st, input bit tick, input logic [7:0] key,
                       input logic [7:0] led);
      bus.i_Remove_Glitch_fStart = st;
      bus.i_Sec1Tick             = tick;
      bus.i_Key                  = key;
      bus.i_Led                  = led;
      if (rst) model_reset();
      else     model_step(st, tick, key, led);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'h00, 8'h00);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.i_Remove_Glitch_fStart = 1'b0;
      bus.i_Sec1Tick = 1'b0;
      bus.i_Key = 8'h00;
      bus.i_Led = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      // Reach score 4 / 17 s left, then assert reset between edges.
      step(1'b1, 1'b0, 8'h00, 8'h00);
      chk("start_time", int'(bus.o_Time_Left), 30);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 8'(1 << i), 8'(1 << i));
         step(1'b0, 1'b1, 8'h00, 8'(1 << i));
      end
      ticks(9);
      chk("pre_rst_score", int'(bus.o_Score), 4);
      chk("pre_rst_time", int'(bus.o_Time_Left), 17);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      step(1'b0, 1'b1, 8'h00, 8'h00);
      rst = 1'b0;
      ticks(2);
      step(1'b0, 1'b0, 8'h01, 8'h01);
      chk("idle_wait", int'(bus.o_State), 0);

      // Timeout with no keys.
      step(1'b1, 1'b0, 8'h00, 8'h00);
      ticks(29);
      chk("to_29_state", int'(bus.o_State), 1);
      chk("to_29_time", int'(bus.o_Time_Left), 1);
      ticks(1);
      chk("timeout_state", int'(bus.o_State), 3);
      chk("timeout_time", int'(bus.o_Time_Left), 0);

      // Start in fail -> idle, second start -> new game.
      step(1'b1, 1'b0, 8'h00, 8'h00);
      chk("fail_abort", int'(bus.o_State), 0);
      step(1'b1, 1'b0, 8'h00, 8'h00);
      chk("restart_state", int'(bus.o_State), 1);
      chk("restart_time", int'(bus.o_Time_Left), 30);

      // Hit, lockout, re-arm on tick.
      step(1'b0, 1'b0, 8'h08, 8'h08);
      chk("hit1_pulse", int'(bus.o_Hit), 1);
      step(1'b0, 1'b0, 8'h08, 8'h08);
      chk("lock_pulse", int'(bus.o_Hit), 0);
      chk("lock_score", int'(bus.o_Score), 1);
      step(1'b0, 1'b1, 8'h00, 8'h08);
      step(1'b0, 1'b0, 8'h20, 8'h20);
      chk("hit2_score", int'(bus.o_Score), 2);

      // Miss handling.
      step(1'b0, 1'b1, 8'h00, 8'h20);
      step(1'b0, 1'b0, 8'h40, 8'h00);
      chk("dark_key_state", int'(bus.o_State), 1);
      step(1'b0, 1'b0, 8'h40, 8'h04);
      chk("miss_state", int'(bus.o_State), 3);
      chk("miss_score", int'(bus.o_Score), 2);

      // Clearing hit on the same cycle as the last tick.
      step(1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b0, 8'(1 << (i % 8)), 8'(1 << (i % 8)));
         step(1'b0, 1'b1, 8'h00, 8'h00);
      end
      ticks(20);
      chk("pre_clr_score", int'(bus.o_Score), 9);
      chk("pre_clr_time", int'(bus.o_Time_Left), 1);
      step(1'b0, 1'b1, 8'h02, 8'h02);
      chk("clr_state", int'(bus.o_State), 2);
      chk("clr_score", int'(bus.o_Score), 10);
      chk("clr_time", int'(bus.o_Time_Left), 0);
      ticks(2);
      chk("hold_state", int'(bus.o_State), 2);
      ticks(1);
      chk("hold_done", int'(bus.o_State), 0);
      chk("idle_score_kept", int'(bus.o_Score), 10);

      // Random play; keys are kept off tick cycles.
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] led;
         logic [7:0] key;
         bit         st;
         bit         tick;
         int         r;
         st   = ($urandom % 48) == 0;
         tick = ($urandom % 6) == 0;
         led  = (($urandom % 4) == 0) ? 8'h00 : 8'(1 << ($urandom % 8));
         r    = int'($urandom % 40);
         if (tick)        key = 8'h00;
         else if (r < 12) key = led | 8'(1 << ($urandom % 8));
         else if (r == 12) key = 8'($urandom);
         else             key = 8'h00;
         step(st, tick, key, led);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
